pe_inject_router: RTL and testbench
===================================

// Module: pe_inject_router
// PURPOSE
//  Parametrised PE-to-switch injection stage for the mesh NoC; successor of the single-register PE injector.
//  Buffers PE flits in a DEPTH-entry FIFO and computes the XY-routing output gate from the head flit.
//  Requests the local switch and, while granted, streams a whole packet wormhole-style, head to tail.
//  Also flags handshake flits to the "signal" block.
// PARAMETERS
//  FLIT_W  32       flit width; header fields are fixed at [FLIT_W-1:FLIT_W-12]
//  COORD_W 2        bits per mesh axis (X, Y)
//  ADDR    4'b0000  this node's address {x[2*COORD_W-1:COORD_W], y[COORD_W-1:0]}
//  DEPTH   4        FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1          rising-edge clock
//  rst             in   1          synchronous reset, active-high
//  in_valid        in   1          PE presents in_flit
//  in_flit         in   FLIT_W     flit from PE
//  in_ready        out  1          FIFO not full; a flit is accepted when in_valid & in_ready
//  grant           in   1          switch grants this port for the current cycle
//  req             out  1          request to switch arbiter
//  out_valid       out  1          flit_out carries a flit this cycle
//  flit_out        out  FLIT_W     flit to switch; all-zero when out_valid=0
//  source          out  2*COORD_W  source field of the current packet
//  gate            out  3          000 N, 001 E, 010 S, 011 W, 100 PE
//  start           out  1          handshake-request seen
//  handshake_check out  2          0 data, 1 sending handshake, 2 returning handshake
//  drop_cnt        out  16         stray body/tail flits dropped (only with PE_INJECT_STATS_EN)
// BEHAVIOUR
//  Flit type [FLIT_W-1:FLIT_W-2]: 11 head; 10 body; 00 tail; 01 handshake return (single flit).
//  A head with bit [FLIT_W-11]=0 is a handshake request (single flit); with =1 it opens a multi-flit packet.
//  Header fields: src [FLIT_W-3 -: 2*COORD_W], dst X next COORD_W bits, dst Y next COORD_W bits.
//  XY route: dstX>myX E; dstX<myX W; otherwise dstY>myY N; dstY<myY S; otherwise PE.
//  FSM IDLE/REQ/SEND:
//   IDLE, FIFO non-empty:
//    - head is body or tail: pop it, drop it, stay in IDLE.
//    - any other head flit: latch gate and source, set start/handshake_check, go to REQ.
//   REQ: req=1. On an edge with grant=1: flit_out<=FIFO head, out_valid<=1, pop, go to SEND.
//    - The pop at this edge closes a single-flit packet: go to IDLE.
//   SEND: req=1. On an edge with grant=1 and FIFO non-empty: forward and pop.
//    - Popping a tail flit: go to IDLE, req=0 on the next cycle.
//    - grant=0 or FIFO empty: out_valid<=0, flit_out<=0, hold state; no flit is lost or duplicated.
//  Latency: a flit accepted at edge N with grant held high appears on flit_out after edge N+2, at the earliest.
//  A handshake request sets start=1 and handshake_check=1; a handshake return sets start=0 and handshake_check=2.
//   A data head sets handshake_check=0; start holds its value until the next handshake flit.
//  FIFO full: in_ready=0.
//   With simultaneous push and pop when full, in_ready stays 0 (registered full flag); the PE retries.
//   With simultaneous push and pop when not full, both complete; the count is unchanged.
//  Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
//  rst, including mid-packet:
//   FIFO is flushed and FSM goes to IDLE.
//   req, out_valid, start=0; flit_out, source, gate, handshake_check=0; in_ready=1 one cycle after rst deasserts.
// CONFIGURATION
//  PE_INJECT_STATS_EN defined:
//   drop_cnt counts dropped stray flits; it saturates at 16'hFFFF and clears on rst.
//  PE_INJECT_STATS_EN undefined:
//   The drop_cnt port and its counter are absent.
//   Stray flits are still dropped silently.
// STRUCTURE
//  noc_pkg holds:
//   - flit-type codes (FT_HEAD, FT_BODY, FT_TAIL, FT_HSRET);
//   - gate codes (GATE_N/E/S/W/PE);
//   - handshake_check codes;
//   - header field offset constants.
//  Sub-module flit_fifo #(W, DEPTH): synchronous FIFO with push, pop, full, empty and head outputs.
//  XY decode and the FSM stay in this module.
// TESTING
//  ADDR=4'b0101, single handshake request to dst 10_01, grant held high -> gate=001, start=1, handshake_check=1; flit_out valid 2 cycles after accept.
//  Head(dst 01_11)+2 body+tail, grant low 3 cycles in mid-packet -> gate=000; 4 flits in order, out_valid=0 during the stall, no duplication.
//  DEPTH=4, 6 flits pushed back-to-back, grant=0 -> in_ready=0 after 4 flits; release grant -> all 6 delivered in order, pointers wrap.
//  Body flit while IDLE with STATS on -> flit not forwarded, drop_cnt=1; head to own address -> gate=100.
//  rst pulsed mid-packet after 2 of 4 flits -> all outputs 0 next cycle, FIFO empty, in_ready=1; a following new packet routes correctly.
//  Handshake return (type 01) -> single-flit send, start=0, handshake_check=2, FSM back in IDLE after one granted cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC constants: flit-type, gate and handshake codes, header field offsets
// and the injection FSM state type.
package noc_pkg;

    localparam logic [1:0] FT_HEAD  = 2'b11;
    localparam logic [1:0] FT_BODY  = 2'b10;
    localparam logic [1:0] FT_TAIL  = 2'b00;
    localparam logic [1:0] FT_HSRET = 2'b01;

    localparam logic [2:0] GATE_N  = 3'b000;
    localparam logic [2:0] GATE_E  = 3'b001;
    localparam logic [2:0] GATE_S  = 3'b010;
    localparam logic [2:0] GATE_W  = 3'b011;
    localparam logic [2:0] GATE_PE = 3'b100;

    localparam logic [1:0] HS_DATA = 2'd0;
    localparam logic [1:0] HS_SEND = 2'd1;
    localparam logic [1:0] HS_RET  = 2'd2;

    // Offsets are counted down from the flit MSB (bit index = FLIT_W - offset).
    localparam int HDR_TYPE_OFS  = 1;
    localparam int HDR_SRC_OFS   = 3;
    localparam int HDR_MULTI_OFS = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } inj_state_e;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO with combinational head output and registered occupancy count;
// full is derived from the registered count, so a pop never frees a slot in the same cycle.
module flit_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // Storage array; flushed logically by the pointer reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_inject_router.sv
// PE-to-switch injection stage: FIFO buffering, XY route decode and wormhole send FSM.
// Optional drop statistics are enabled by defining PE_INJECT_STATS_EN.
module pe_inject_router
    import noc_pkg::*;
#(
    parameter int                   FLIT_W  = 32,
    parameter int                   COORD_W = 2,
    parameter logic [2*COORD_W-1:0] ADDR    = {(2*COORD_W){1'b0}},
    parameter int                   DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [FLIT_W-1:0]    in_flit,
    output logic                 in_ready,
    input  logic                 grant,
    output logic                 req,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    flit_out,
    output logic [2*COORD_W-1:0] source,
    output logic [2:0]           gate,
    output logic                 start,
    output logic [1:0]           handshake_check
`ifdef PE_INJECT_STATS_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int DX_MSB = FLIT_W - HDR_SRC_OFS - 2*COORD_W;
    localparam int DY_MSB = DX_MSB - COORD_W;
    localparam logic [COORD_W-1:0] MY_X = ADDR[2*COORD_W-1:COORD_W];
    localparam logic [COORD_W-1:0] MY_Y = ADDR[COORD_W-1:0];

    logic [FLIT_W-1:0]    head_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 pop_s;
    logic [1:0]           head_type_s;
    logic                 head_multi_s;
    logic                 head_stray_s;
    logic [2*COORD_W-1:0] head_src_s;
    logic [COORD_W-1:0]   dst_x_s;
    logic [COORD_W-1:0]   dst_y_s;
    logic [2:0]           route_gate_s;

    inj_state_e           state_q,     state_d;
    logic                 req_q,       req_d;
    logic                 out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]    flit_out_q,  flit_out_d;
    logic [2*COORD_W-1:0] source_q,    source_d;
    logic [2:0]           gate_q,      gate_d;
    logic                 start_q,     start_d;
    logic [1:0]           hs_q,        hs_d;
    logic                 single_q,    single_d;

    flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop_s),
        .data_i  (in_flit),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign in_ready     = ~full_s;
    assign head_type_s  = head_s[FLIT_W-HDR_TYPE_OFS -: 2];
    assign head_multi_s = head_s[FLIT_W-HDR_MULTI_OFS];
    assign head_src_s   = head_s[FLIT_W-HDR_SRC_OFS -: 2*COORD_W];
    assign dst_x_s      = head_s[DX_MSB -: COORD_W];
    assign dst_y_s      = head_s[DY_MSB -: COORD_W];
    assign head_stray_s = (head_type_s == FT_BODY) || (head_type_s == FT_TAIL);

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    always_comb begin
        route_gate_s = GATE_PE;
        if (dst_x_s > MY_X) begin
            route_gate_s = GATE_E;
        end else if (dst_x_s < MY_X) begin
            route_gate_s = GATE_W;
        end else if (dst_y_s > MY_Y) begin
            route_gate_s = GATE_N;
        end else if (dst_y_s < MY_Y) begin
            route_gate_s = GATE_S;
        end else begin
            route_gate_s = GATE_PE;
        end
    end

    // Next-state and registered-output logic of the injection FSM.
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        out_valid_d = 1'b0;
        flit_out_d  = {FLIT_W{1'b0}};
        source_d    = source_q;
        gate_d      = gate_q;
        start_d     = start_q;
        hs_d        = hs_q;
        single_d    = single_q;
        case (state_q)
            ST_IDLE: begin
                if (empty_s) begin
                    state_d = ST_IDLE;
                end else if (head_stray_s) begin
                    pop_s = 1'b1;
                end else begin
                    gate_d   = route_gate_s;
                    source_d = head_src_s;
                    state_d  = ST_REQ;
                    if (head_type_s == FT_HSRET) begin
                        single_d = 1'b1;
                        start_d  = 1'b0;
                        hs_d     = HS_RET;
                    end else if (!head_multi_s) begin
                        single_d = 1'b1;
                        start_d  = 1'b1;
                        hs_d     = HS_SEND;
                    end else begin
                        single_d = 1'b0;
                        hs_d     = HS_DATA;
                    end
                end
            end
            ST_REQ: begin
                if (grant) begin
                    out_valid_d = 1'b1;
                    flit_out_d  = head_s;
                    pop_s       = 1'b1;
                    state_d     = single_q ? ST_IDLE : ST_SEND;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SEND: begin
                // A stall (no grant or no data) simply holds; the head stays in the FIFO.
                if (grant && !empty_s) begin
                    out_valid_d = 1'b1;
                    flit_out_d  = head_s;
                    pop_s       = 1'b1;
                    state_d     = (head_type_s == FT_TAIL) ? ST_IDLE : ST_SEND;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d != ST_IDLE);
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            flit_out_q  <= {FLIT_W{1'b0}};
            source_q    <= {(2*COORD_W){1'b0}};
            gate_q      <= 3'b000;
            start_q     <= 1'b0;
            hs_q        <= 2'b00;
            single_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            flit_out_q  <= flit_out_d;
            source_q    <= source_d;
            gate_q      <= gate_d;
            start_q     <= start_d;
            hs_q        <= hs_d;
            single_q    <= single_d;
        end
    end

    assign req             = req_q;
    assign out_valid       = out_valid_q;
    assign flit_out        = flit_out_q;
    assign source          = source_q;
    assign gate            = gate_q;
    assign start           = start_q;
    assign handshake_check = hs_q;

`ifdef PE_INJECT_STATS_EN
    logic        drop_s;
    logic [15:0] drop_cnt_q;

    assign drop_s   = (state_q == ST_IDLE) && !empty_s && head_stray_s;
    assign drop_cnt = drop_cnt_q;

    // Saturating count of stray flits discarded while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'h0000;
        end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'h0001;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_pe_inject_router.sv
// Self-checking bench for pe_inject_router: directed scenarios plus randomized packets
// compared against a packet-level reference model.
module tb_pe_inject_router;

    localparam int         FW    = 32;
    localparam int         CW    = 2;
    localparam int         DEPTH = 4;
    localparam logic [3:0] MY    = 4'b0101;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic        grant;
    logic        req;
    logic        out_valid;
    logic [31:0] flit_out;
    logic [3:0]  source;
    logic [2:0]  gate;
    logic        start;
    logic [1:0]  handshake_check;
`ifdef PE_INJECT_STATS_EN
    logic [15:0] drop_cnt;
`endif

    pe_inject_router #(
        .FLIT_W  (FW),
        .COORD_W (CW),
        .ADDR    (MY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .grant           (grant),
        .req             (req),
        .out_valid       (out_valid),
        .flit_out        (flit_out),
        .source          (source),
        .gate            (gate),
        .start           (start),
        .handshake_check (handshake_check)
`ifdef PE_INJECT_STATS_EN
        ,
        .drop_cnt        (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] flit;
        bit          first;
        logic [2:0]  gate;
        logic [3:0]  src;
        logic [1:0]  hs;
        bit          st;
    } exp_t;

    exp_t exp_q[$];
    bit   pkt_open;
    bit   model_start;
    int   model_drops;
    int   n_cmp;
    int   n_mis;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] xy_gate(input logic [3:0] dst);
        int dx = int'(dst[3:2]);
        int dy = int'(dst[1:0]);
        int mx = int'(MY[3:2]);
        int my = int'(MY[1:0]);
        if (dx > mx) return 3'b001;
        if (dx < mx) return 3'b011;
        if (dy > my) return 3'b000;
        if (dy < my) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [31:0] mk_flit(input logic [1:0] ty, input logic [3:0] src,
                                            input logic [3:0] dst, input bit multi);
        logic [31:0] f = $urandom();
        f[31:30] = ty;
        f[29:26] = src;
        f[25:22] = dst;
        f[21]    = multi;
        return f;
    endfunction

    // Packet-level model: parses the accepted stream into packets and stray flits.
    task automatic model_accept(input logic [31:0] f);
        exp_t e;
        logic [1:0] ty = f[31:30];
        e.flit  = f;
        e.first = 1'b0;
        e.gate  = 3'b000;
        e.src   = 4'h0;
        e.hs    = 2'd0;
        e.st    = 1'b0;
        if (!pkt_open) begin
            if (ty == 2'b10 || ty == 2'b00) begin
                model_drops++;
            end else begin
                e.first = 1'b1;
                e.gate  = xy_gate(f[25:22]);
                e.src   = f[29:26];
                if (ty == 2'b01) begin
                    model_start = 1'b0;
                    e.hs = 2'd2;
                end else if (!f[21]) begin
                    model_start = 1'b1;
                    e.hs = 2'd1;
                end else begin
                    e.hs = 2'd0;
                    pkt_open = 1'b1;
                end
                e.st = model_start;
                exp_q.push_back(e);
            end
        end else begin
            exp_q.push_back(e);
            if (ty == 2'b00) pkt_open = 1'b0;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk_val("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk_val("flit", flit_out, e.flit);
                if (e.first) begin
                    chk_val("gate", gate, e.gate);
                    chk_val("source", source, e.src);
                    chk_val("hs_check", handshake_check, e.hs);
                    chk_val("start", start, e.st);
                end
            end
        end else begin
            chk_val("idle_flit_zero", flit_out, 32'h0);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] f, input bit g, output bit acc);
        in_valid = v;
        in_flit  = f;
        grant    = g;
        acc      = v && in_ready && !rst;
        tick();
        if (acc) model_accept(f);
    endtask

    // mode: 0 grant low, 1 grant high, 2 random grant
    task automatic push(input logic [31:0] f, input int mode);
        bit acc = 1'b0;
        bit g;
        for (int i = 0; i < 60 && !acc; i++) begin
            g = (mode == 2) ? ($urandom_range(3, 0) != 0) : (mode == 1);
            drive(1'b1, f, g, acc);
        end
        in_valid = 1'b0;
        if (!acc) chk_val("push_timeout", in_ready, 1'b1);
    endtask

    task automatic idle(input int n, input bit g);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, g, acc);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            idle(1, 1'b1);
            k++;
        end
        chk_val("drain_empty", exp_q.size(), 0);
        idle(2, 1'b1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        grant    = 1'b0;
        exp_q.delete();
        pkt_open    = 1'b0;
        model_start = 1'b0;
        model_drops = 0;
        tick();
        chk_val("rst_req", req, 1'b0);
        chk_val("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_start", start, 1'b0);
        chk_val("rst_source", source, 4'h0);
        chk_val("rst_gate", gate, 3'b000);
        chk_val("rst_hs", handshake_check, 2'd0);
        rst = 1'b0;
        tick();
        chk_val("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        bit          acc;
        logic [31:0] f;
        int          k;
        int          nb;
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_flit = 32'h0;
        grant = 1'b0;
        do_reset();

        // Handshake request to 10_01: east, two-cycle latency.
        drive(1'b1, mk_flit(2'b11, 4'h3, 4'b1001, 1'b0), 1'b1, acc);
        in_valid = 1'b0;
        chk_val("hs_accept", acc, 1'b1);
        idle(1, 1'b1);
        chk_val("lat_edge1", out_valid, 1'b0);
        idle(1, 1'b1);
        chk_val("lat_edge2", out_valid, 1'b1);
        chk_val("hs_gate_e", gate, 3'b001);
        idle(1, 1'b1);
        chk_val("req_after_single", req, 1'b0);

        // Data packet to 01_11 with a three-cycle grant stall.
        push(mk_flit(2'b11, 4'h6, 4'b0111, 1'b1), 1);
        push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 1);
        push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 1);
        push(mk_flit(2'b00, 4'h0, 4'h0, 1'b0), 1);
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b0);
            chk_val("stall_out_valid", out_valid, 1'b0);
        end
        drain();
        chk_val("data_gate_n", gate, 3'b000);
        chk_val("data_hs", handshake_check, 2'd0);

        // Six-flit packet against a four-entry FIFO with grant low.
        push(mk_flit(2'b11, 4'h1, 4'b1111, 1'b1), 0);
        for (int i = 0; i < 3; i++) push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 0);
        chk_val("full_in_ready", in_ready, 1'b0);
        drive(1'b1, mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 1'b0, acc);
        chk_val("full_reject", acc, 1'b0);
        chk_val("full_still", in_ready, 1'b0);
        push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 1);
        push(mk_flit(2'b00, 4'h0, 4'h0, 1'b0), 1);
        drain();

        // Stray body while idle, then a handshake request to our own node.
        push(mk_flit(2'b10, 4'h2, 4'h0, 1'b0), 1);
        idle(3, 1'b1);
`ifdef PE_INJECT_STATS_EN
        chk_val("drop_cnt_one", drop_cnt, 16'd1);
`endif
        push(mk_flit(2'b11, 4'h9, MY, 1'b0), 1);
        drain();
        chk_val("own_gate", gate, 3'b100);

        // Handshake return: single flit, start cleared, back to idle.
        push(mk_flit(2'b01, 4'hA, 4'b0001, 1'b0), 1);
        idle(2, 1'b1);
        chk_val("ret_start", start, 1'b0);
        chk_val("ret_hs", handshake_check, 2'd2);
        idle(1, 1'b1);
        chk_val("ret_req_low", req, 1'b0);
        drain();

        // Reset in mid-packet, then a fresh packet towards the west.
        push(mk_flit(2'b11, 4'h4, 4'b1101, 1'b1), 1);
        push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 1);
        idle(2, 1'b1);
        do_reset();
        chk_val("post_rst_out", out_valid, 1'b0);
        push(mk_flit(2'b11, 4'h5, 4'b0001, 1'b0), 1);
        drain();
        chk_val("post_rst_gate_w", gate, 3'b011);

        // Randomized packet mix with random grant and gaps.
        for (int p = 0; p < 40; p++) begin
            k = $urandom_range(3, 0);
            case (k)
                0: push(mk_flit(2'b11, 4'($urandom), 4'($urandom), 1'b0), 2);
                1: push(mk_flit(2'b01, 4'($urandom), 4'($urandom), 1'b0), 2);
                2: begin
                    push(mk_flit(2'b11, 4'($urandom), 4'($urandom), 1'b1), 2);
                    nb = $urandom_range(3, 0);
                    for (int b = 0; b < nb; b++) push(mk_flit(2'b10, 4'h0, 4'h0, 1'b0), 2);
                    push(mk_flit(2'b00, 4'h0, 4'h0, 1'b0), 2);
                end
                default: begin
                    f = mk_flit(($urandom_range(1, 0) != 0) ? 2'b10 : 2'b00, 4'h0, 4'h0, 1'b0);
                    push(f, 2);
                end
            endcase
            idle($urandom_range(2, 0), $urandom_range(1, 0) != 0);
        end
        drain();
        chk_val("rand_in_ready", in_ready, 1'b1);
`ifdef PE_INJECT_STATS_EN
        chk_val("rand_drop_cnt", drop_cnt, 16'(model_drops));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
